// File: rtl/rib_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rib_timer
//  Description : RIB bus responder timer. Zero-wait-state register file with
//                a free-running / one-shot up-counter, compare match, pending
//                flag (write-1-to-clear) and a level interrupt output.
//                Optional 8-bit prescaler enabled by macro
//                RIB_TIMER_PRESCALER_EN (CTRL[15:8] = PRESCALE).
//  Revision    : 1.0 - initial release
// ============================================================================
module rib_timer #(
   parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic        we_i,
   input  logic        req_i,
   output logic [31:0] data_o,
   output logic        int_o
);

   // Word offsets decoded from addr_i[3:2]
   localparam logic [1:0] c_addr_ctrl   = 2'd0;
   localparam logic [1:0] c_addr_count  = 2'd1;
   localparam logic [1:0] c_addr_cmp    = 2'd2;
   localparam logic [1:0] c_addr_status = 2'd3;

   logic        r_en;
   logic        r_oneshot;
   logic        r_ie;
   logic [31:0] r_count;
   logic [31:0] r_cmp;
   logic        r_pend;
   logic [7:0]  w_prescale_rd;

   logic        w_wr;
   logic        w_rd;
   logic        w_wr_ctrl;
   logic        w_wr_count;
   logic        w_wr_cmp;
   logic        w_wr_status;
   logic        w_tick;
   logic        w_match;
   logic        w_unused_addr;

   // Slave select is done upstream; only the word offset matters here
   assign w_unused_addr = ^{addr_i[31:4], addr_i[1:0]};

   assign w_wr        = req_i & we_i;
   assign w_rd        = req_i & ~we_i;
   assign w_wr_ctrl   = w_wr && (addr_i[3:2] == c_addr_ctrl);
   assign w_wr_count  = w_wr && (addr_i[3:2] == c_addr_count);
   assign w_wr_cmp    = w_wr && (addr_i[3:2] == c_addr_cmp);
   assign w_wr_status = w_wr && (addr_i[3:2] == c_addr_status);

`ifdef RIB_TIMER_PRESCALER_EN
   logic [7:0] r_prescale;
   logic [7:0] r_psc_cnt;

   // PRESCALE field of CTRL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prescale <= 8'd0;
      end else if (w_wr_ctrl) begin
         r_prescale <= data_i[15:8];
      end
   end

   // Prescaler counter: wraps to 0 on the tick cycle, cleared by disabling write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_psc_cnt <= 8'd0;
      end else if (w_wr_ctrl && !data_i[0]) begin
         r_psc_cnt <= 8'd0;
      end else if (r_en) begin
         if (r_psc_cnt == r_prescale) begin
            r_psc_cnt <= 8'd0;
         end else begin
            r_psc_cnt <= r_psc_cnt + 8'd1;
         end
      end
   end

   assign w_tick        = r_en && (r_psc_cnt == r_prescale);
   assign w_prescale_rd = r_prescale;
`else
   assign w_tick        = r_en;
   assign w_prescale_rd = 8'd0;
`endif

   assign w_match = w_tick && (r_count == r_cmp);

   // CTRL flags; a software write overrides the one-shot auto-disable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en      <= 1'b0;
         r_oneshot <= 1'b0;
         r_ie      <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en      <= data_i[0];
         r_oneshot <= data_i[1];
         r_ie      <= data_i[2];
      end else if (w_match && r_oneshot) begin
         r_en      <= 1'b0;
      end
   end

   // COUNT: software write wins over a tick in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 32'd0;
      end else if (w_wr_count) begin
         r_count <= data_i;
      end else if (w_match) begin
         r_count <= 32'd0;
      end else if (w_tick) begin
         r_count <= r_count + 32'd1;
      end
   end

   // CMP register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmp <= CMP_RST;
      end else if (w_wr_cmp) begin
         r_cmp <= data_i;
      end
   end

   // PEND: a match sets, write-1 clears, set takes priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= 1'b0;
      end else if (w_match) begin
         r_pend <= 1'b1;
      end else if (w_wr_status && data_i[0]) begin
         r_pend <= 1'b0;
      end
   end

   // Interrupt built only from register outputs so it cannot glitch
   assign int_o = r_pend & r_ie;

   // Zero-latency read mux; bus idles at 0 when not reading
   always_comb begin
      data_o = 32'd0;
      if (w_rd) begin
         case (addr_i[3:2])
            c_addr_ctrl:   data_o = {16'd0, w_prescale_rd, 5'd0, r_ie, r_oneshot, r_en};
            c_addr_count:  data_o = r_count;
            c_addr_cmp:    data_o = r_cmp;
            c_addr_status: data_o = {31'd0, r_pend};
            default:       data_o = 32'd0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/rib_timer.md
# rib_timer

Memory-mapped timer peripheral acting as a responder (slave) on the RIB bus, the counterpart of the core's `rib_ex_*` initiator port. It decodes single-cycle read/write requests from the core. It provides a free-running or one-shot up-counter with compare match, an optional prescaler, and a level interrupt line suitable for the core's `int_i` bus. The block is zero-wait-state and never requests a bus hold.

## Interface
- `CMP_RST`, default 32'hFFFF_FFFF: reset value of the CMP register.
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `addr_i` input 32: RIB address; only `addr_i[3:2]` decoded, slave select done upstream.
- `data_i` input 32: RIB write data.
- `we_i` input 1: write enable, qualified by `req_i`.
- `req_i` input 1: request valid for this slave in the current cycle.
- `data_o` output 32: read data, combinational.
- `int_o` output 1: timer interrupt, level, active-high.

## Operation
- Register map, word offsets:
  - 0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE, bits[15:8] PRESCALE. PRESCALE exists only with the macro.
  - 0x4 COUNT: read/write.
  - 0x8 CMP: read/write.
  - 0xC STATUS: bit0 PEND, write-1-to-clear. Writing 0 has no effect.
- Unused CTRL/STATUS bits read 0 and ignore writes.
- Write: when `req_i & we_i`, the addressed register is updated at the next rising edge.
- Read: when `req_i & ~we_i`, `data_o` holds the addressed register's current value in the same cycle. Otherwise `data_o` = 0.
- Tick: counting event, generated only while EN=1.
- On tick:
  - If COUNT == CMP: COUNT←0 and PEND←1. If ONESHOT=1, EN←0.
  - Otherwise COUNT←COUNT+1, modulo 2^32.
- CMP=0: a match occurs on every tick and COUNT stays 0.
- `int_o` = PEND & IE, both taken from registers, so the output is glitch-free.
- Simultaneous events:
  - Software write to COUNT and a tick in the same cycle: the software write wins.
  - Software write to CTRL and a one-shot match in the same cycle: the written EN wins.
  - STATUS W1C and a match in the same cycle: set wins, PEND=1.
- Writing CTRL with EN=0 clears the prescaler counter.

## Timing
- Reset values:
  - CTRL=0, COUNT=0, CMP=`CMP_RST`, PEND=0, prescaler counter=0.
  - `int_o`=0, `data_o`=0 (no request).
- Read latency is 0 cycles. Write effect is visible on reads from the cycle after the request.
- Write a match condition in cycle N: PEND rises at edge N+1 and `int_o` is high in cycle N+1.
- COUNT changes at most once per tick edge. Reads return the pre-edge value.
- Reset asserted mid-count clears all state immediately (asynchronous). Counting resumes only after software sets EN.

## Configuration
- Macro `RIB_TIMER_PRESCALER_EN`.
- Defined:
  - 8-bit prescaler counter; a tick is issued on the cycle it equals PRESCALE, then it wraps to 0.
  - Tick rate is clk/(PRESCALE+1). PRESCALE=0 gives a tick every cycle.
  - PRESCALE is read/write in CTRL[15:8].
- Undefined:
  - No prescaler logic; tick = EN every cycle.
  - CTRL[15:8] reads 0 and writes are ignored.

## Test plan
- Reset, then read all four offsets -> 0, 0, 32'hFFFF_FFFF, 0. `int_o`=0.
- Write CMP=5, CTRL=0x5 (EN, IE, periodic) -> COUNT sequence 1..5 then 0. PEND=1 and `int_o`=1 six cycles after enable. Pattern repeats every 6 cycles.
- ONESHOT: CMP=3, CTRL=0x3 -> single match, then EN reads 0 and COUNT holds 0. Write STATUS=1 -> PEND=0 and `int_o`=0 next cycle.
- Same-cycle STATUS W1C and match -> PEND remains 1. Same-cycle COUNT write 0x100 and tick -> COUNT reads 0x100.
- With `RIB_TIMER_PRESCALER_EN`: CTRL=0x0301, CMP=2 -> COUNT increments every 4 cycles and matches after 12 cycles. Without the macro: CTRL reads 0x1.
- Assert `rst` while COUNT=0x20 and PEND=1 -> all registers at reset values in the same cycle. `int_o` drops asynchronously.
